// File: rtl/inst_issue_queue.sv
`default_nettype none
// ============================================================================
// inst_issue_queue : IF/ID circular queue, 2-in / 2-out; IQ_BYPASS_EN = 0-cycle path
// Rev 1.0
// ============================================================================
module inst_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               If_Valid,
    input  logic [INST_WIDTH-1:0]    If_Inst0,
    input  logic [INST_WIDTH-1:0]    If_Inst1,
    input  logic [PC_WIDTH-1:0]      If_PC0,
    input  logic [PC_WIDTH-1:0]      If_PC1,
    input  logic [4:0]               Ctrl_Stall,
    input  logic [3:0]               Flush,
    input  logic                     EX_BranchFlag,
    input  logic                     Csr_ExcpFlag,
    input  logic [1:0]               Id_IssueNum,
    output logic [1:0]               IQ_Valid,
    output logic [INST_WIDTH-1:0]    IQ_Inst0,
    output logic [INST_WIDTH-1:0]    IQ_Inst1,
    output logic [PC_WIDTH-1:0]      IQ_PC0,
    output logic [PC_WIDTH-1:0]      IQ_PC1,
    output logic                     IQ_StallReq,
    output logic [$clog2(DEPTH):0]   IQ_Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  w_flush, w_hold, w_stall_req, w_bypass;
    logic [1:0]            w_issue, w_deq_n, w_in_n, w_skip, w_wr_n;
    logic [INST_WIDTH-1:0] w_in_inst0, w_wr_inst0;
    logic [PC_WIDTH-1:0]   w_in_pc0, w_wr_pc0;
    logic [PW-1:0]         w_head_p1, w_tail_p1;
    logic                  w_unused_ok;

    assign w_unused_ok = ^{Ctrl_Stall[4:2], Ctrl_Stall[0], Flush[3:1]};

    assign w_flush     = Flush[0] | EX_BranchFlag | Csr_ExcpFlag;
    assign w_hold      = Ctrl_Stall[1];
    assign w_stall_req = count_q > CW'(DEPTH - 2);
    assign w_issue     = (Id_IssueNum == 2'd3) ? 2'd2 : Id_IssueNum;
    assign w_head_p1   = head_q + PW'(1);
    assign w_tail_p1   = tail_q + PW'(1);

    // A lone slot-1 instruction is packed down into the first incoming position.
    always_comb begin
        w_in_n     = 2'd0;
        w_in_inst0 = If_Inst0;
        w_in_pc0   = If_PC0;
        case (If_Valid)
            2'b01: w_in_n = 2'd1;
            2'b10: begin
                w_in_n     = 2'd1;
                w_in_inst0 = If_Inst1;
                w_in_pc0   = If_PC1;
            end
            2'b11: w_in_n = 2'd2;
            default: w_in_n = 2'd0;
        endcase
    end

`ifdef IQ_BYPASS_EN
    assign w_bypass = rst_n && (count_q == '0) && !w_flush && !w_hold;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_skip  = w_bypass ? ((w_in_n >= w_issue) ? w_issue : w_in_n) : 2'd0;
    assign w_deq_n = (w_hold || w_bypass) ? 2'd0 :
                     (count_q >= CW'(w_issue)) ? w_issue : count_q[1:0];
    assign w_wr_n  = (w_flush || w_stall_req) ? 2'd0 : (w_in_n - w_skip);

    // When one bypassed instruction was consumed, only the second remains to write.
    assign w_wr_inst0 = (w_skip != 2'd0) ? If_Inst1 : w_in_inst0;
    assign w_wr_pc0   = (w_skip != 2'd0) ? If_PC1   : w_in_pc0;

    always_comb begin
        head_d  = head_q + PW'(w_deq_n);
        tail_d  = tail_q + PW'(w_wr_n);
        count_d = count_q + CW'(w_wr_n) - CW'(w_deq_n);
        if (w_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (w_wr_n != 2'd0) begin
                inst_q[tail_q] <= w_wr_inst0;
                pc_q[tail_q]   <= w_wr_pc0;
            end
            if (w_wr_n == 2'd2) begin
                inst_q[w_tail_p1] <= If_Inst1;
                pc_q[w_tail_p1]   <= If_PC1;
            end
        end
    end

    always_comb begin
        IQ_Valid = {count_q >= CW'(2), count_q != '0};
        IQ_Inst0 = inst_q[head_q];
        IQ_PC0   = pc_q[head_q];
        IQ_Inst1 = inst_q[w_head_p1];
        IQ_PC1   = pc_q[w_head_p1];
        if (w_bypass) begin
            IQ_Valid = (w_in_n == 2'd2) ? 2'b11 : (w_in_n == 2'd1) ? 2'b01 : 2'b00;
            IQ_Inst0 = w_in_inst0;
            IQ_PC0   = w_in_pc0;
            IQ_Inst1 = If_Inst1;
            IQ_PC1   = If_PC1;
        end
    end

    assign IQ_StallReq = w_stall_req;
    assign IQ_Count    = count_q;

    // Fetch is expected to honour IQ_StallReq; anything offered anyway is lost.
    always @(posedge clk) begin
        if (rst_n) begin
            a_enq_dropped: assert (!(w_stall_req && !w_flush && (If_Valid != 2'b00)))
                else $warning("inst_issue_queue: enqueue dropped while IQ_StallReq=1");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_issue_queue : queue-model checker plus directed literal checks
// Rev 1.0
// ============================================================================
module tb_inst_issue_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  If_Valid = '0;
    logic [31:0] If_Inst0 = '0, If_Inst1 = '0, If_PC0 = '0, If_PC1 = '0;
    logic [4:0]  Ctrl_Stall = '0;
    logic [3:0]  Flush = '0;
    logic        EX_BranchFlag = 1'b0, Csr_ExcpFlag = 1'b0;
    logic [1:0]  Id_IssueNum = '0;
    logic [1:0]  IQ_Valid;
    logic [31:0] IQ_Inst0, IQ_Inst1, IQ_PC0, IQ_PC1;
    logic        IQ_StallReq;
    logic [2:0]  IQ_Count;

    int checks = 0;
    int errors = 0;

    inst_issue_queue #(.DEPTH(DEPTH), .INST_WIDTH(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .If_Valid(If_Valid), .If_Inst0(If_Inst0), .If_Inst1(If_Inst1),
        .If_PC0(If_PC0), .If_PC1(If_PC1),
        .Ctrl_Stall(Ctrl_Stall), .Flush(Flush),
        .EX_BranchFlag(EX_BranchFlag), .Csr_ExcpFlag(Csr_ExcpFlag),
        .Id_IssueNum(Id_IssueNum),
        .IQ_Valid(IQ_Valid), .IQ_Inst0(IQ_Inst0), .IQ_Inst1(IQ_Inst1),
        .IQ_PC0(IQ_PC0), .IQ_PC1(IQ_PC1),
        .IQ_StallReq(IQ_StallReq), .IQ_Count(IQ_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Incoming fetch group as an ordered list (lone slot 1 counts as one entry)
    ent_t inc[$];
    always_comb begin
        inc = {};
        if (If_Valid[0]) inc.push_back('{If_Inst0, If_PC0});
        if (If_Valid[1]) inc.push_back('{If_Inst1, If_PC1});
    end

    logic flush_now;
    int   iss;
    assign flush_now = Flush[0] | EX_BranchFlag | Csr_ExcpFlag;
    assign iss = (Id_IssueNum == 2'd3) ? 2 : int'(Id_IssueNum);

    function automatic logic bypass_now(int sz);
`ifdef IQ_BYPASS_EN
        return (sz == 0) && !flush_now && !Ctrl_Stall[1];
`else
        return (sz == 0) && 1'b0;
`endif
    endfunction

    // Reference queue
    ent_t mq[$];
    ent_t rest[$];
    int   deq, take;
    logic room;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush_now) begin
            mq.delete();
        end else if (bypass_now(mq.size())) begin
            take = (iss < inc.size()) ? iss : inc.size();
            rest = inc;
            repeat (take) void'(rest.pop_front());
            foreach (rest[k]) mq.push_back(rest[k]);
        end else begin
            room = (DEPTH - mq.size()) >= 2;
            deq  = Ctrl_Stall[1] ? 0 : ((iss < mq.size()) ? iss : mq.size());
            repeat (deq) void'(mq.pop_front());
            if (room) foreach (inc[k]) mq.push_back(inc[k]);
        end
    end

    // Per-cycle comparison against the reference queue
    logic [1:0]  e_v;
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
    int          e_cnt;
    logic        e_sr;
    always @(negedge clk) begin
        e_i0 = '0; e_p0 = '0; e_i1 = '0; e_p1 = '0;
        e_v = 2'b00; e_cnt = 0; e_sr = 1'b0;
        if (rst_n) begin
            e_cnt = mq.size();
            e_sr  = (DEPTH - e_cnt) < 2;
            e_v   = {e_cnt >= 2, e_cnt >= 1};
            if (e_cnt >= 1) begin e_i0 = mq[0].inst; e_p0 = mq[0].pc; end
            if (e_cnt >= 2) begin e_i1 = mq[1].inst; e_p1 = mq[1].pc; end
            if (bypass_now(e_cnt)) begin
                e_v = (inc.size() == 2) ? 2'b11 : (inc.size() == 1) ? 2'b01 : 2'b00;
                if (inc.size() >= 1) begin e_i0 = inc[0].inst; e_p0 = inc[0].pc; end
                if (inc.size() >= 2) begin e_i1 = inc[1].inst; e_p1 = inc[1].pc; end
            end
        end
        chk("cmp_count", 32'(IQ_Count), 32'(e_cnt));
        chk("cmp_valid", 32'(IQ_Valid), 32'(e_v));
        chk("cmp_stallreq", 32'(IQ_StallReq), 32'(e_sr));
        if (!rst_n || e_v[0]) begin
            chk("cmp_inst0", IQ_Inst0, e_i0);
            chk("cmp_pc0", IQ_PC0, e_p0);
        end
        if (!rst_n || e_v[1]) begin
            chk("cmp_inst1", IQ_Inst1, e_i1);
            chk("cmp_pc1", IQ_PC1, e_p1);
        end
    end

    task automatic idle();
        If_Valid = 2'b00; Ctrl_Stall = '0; Flush = '0;
        EX_BranchFlag = 1'b0; Csr_ExcpFlag = 1'b0; Id_IssueNum = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic fetch(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        If_Valid = v; If_Inst0 = i0; If_PC0 = p0; If_Inst1 = i1; If_PC1 = p1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_count", 32'(IQ_Count), 32'd0);
        chk("rst_valid", 32'(IQ_Valid), 32'd0);
        chk("rst_stallreq", 32'(IQ_StallReq), 32'd0);
        chk("rst_inst0", IQ_Inst0, 32'd0);

        // Fill to full, then an enqueue that must be dropped
        fetch(2'b11, 32'hA, 32'h100, 32'hB, 32'h104); step();
        chk("fill1_count", 32'(IQ_Count), 32'd2);
        chk("fill1_inst1", IQ_Inst1, 32'hB);
        fetch(2'b11, 32'hC, 32'h108, 32'hD, 32'h10C); step();
        chk("fill2_count", 32'(IQ_Count), 32'd4);
        chk("fill2_stallreq", 32'(IQ_StallReq), 32'd1);
        fetch(2'b11, 32'hE, 32'h110, 32'hF, 32'h114); step();
        chk("drop_count", 32'(IQ_Count), 32'd4);
        chk("drop_inst0", IQ_Inst0, 32'hA);
        Id_IssueNum = 2'd1; step();
        chk("deq1_count", 32'(IQ_Count), 32'd3);

        // Asynchronous reset with three entries held
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(IQ_Valid), 32'd0);
        chk("arst_count", 32'(IQ_Count), 32'd0);
        chk("arst_stallreq", 32'(IQ_StallReq), 32'd0);
        step();
        rst_n = 1'b1;

        // Dual issue from {A,B,C}
        fetch(2'b11, 32'hA, 32'h100, 32'hB, 32'h104); step();
        fetch(2'b01, 32'hC, 32'h108, 32'h0, 32'h0); step();
        chk("abc_count", 32'(IQ_Count), 32'd3);
        Id_IssueNum = 2'd2; step();
        chk("dual_inst0", IQ_Inst0, 32'hC);
        chk("dual_valid", 32'(IQ_Valid), 32'b01);
        fetch(2'b11, 32'hD, 32'h10C, 32'hE, 32'h110); Id_IssueNum = 2'd1; step();
        chk("enqdeq_count", 32'(IQ_Count), 32'd2);
        chk("enqdeq_pc1", IQ_PC1, 32'h110);

        // Stall: no dequeue, but enqueue still accepted
        Ctrl_Stall = 5'b00011; Id_IssueNum = 2'd2; step();
        chk("stall_count", 32'(IQ_Count), 32'd2);
        chk("stall_inst0", IQ_Inst0, 32'hD);
        Ctrl_Stall = 5'b00010; Id_IssueNum = 2'd2; fetch(2'b01, 32'hF, 32'h114, 32'h0, 32'h0); step();
        chk("stall_enq_count", 32'(IQ_Count), 32'd3);

        // Branch flush beats simultaneous enqueue
        EX_BranchFlag = 1'b1; fetch(2'b11, 32'h77, 32'h200, 32'h78, 32'h204); step();
        chk("flush_count", 32'(IQ_Count), 32'd0);
        chk("flush_valid", 32'(IQ_Valid), 32'b00);
        fetch(2'b01, 32'h10, 32'h300, 32'h0, 32'h0); step();
        chk("postflush_inst0", IQ_Inst0, 32'h10);

        // Walk head to DEPTH-1, then wrap and pack
        fetch(2'b11, 32'h11, 32'h304, 32'h12, 32'h308); step();
        Id_IssueNum = 2'd2; step();
        fetch(2'b01, 32'h13, 32'h30C, 32'h0, 32'h0); Id_IssueNum = 2'd1; step();
        fetch(2'b01, 32'h14, 32'h310, 32'h0, 32'h0); step();
        chk("wrap_pc0", IQ_PC0, 32'h30C);
        chk("wrap_pc1", IQ_PC1, 32'h310);
        fetch(2'b10, 32'hDEAD, 32'hBAD0, 32'h15, 32'h314); step();
        chk("pack_count", 32'(IQ_Count), 32'd3);
        Id_IssueNum = 2'd2; step();
        chk("pack_inst0", IQ_Inst0, 32'h15);
        chk("pack_pc0", IQ_PC0, 32'h314);

        // Issue number 3 clipped to 2
        fetch(2'b11, 32'h16, 32'h318, 32'h17, 32'h31C); step();
        Id_IssueNum = 2'd3; step();
        chk("clip_count", 32'(IQ_Count), 32'd1);
        chk("clip_inst0", IQ_Inst0, 32'h17);

        // IF/ID flush bit and trap flush
        Flush = 4'b0001; step();
        chk("ifid_flush_count", 32'(IQ_Count), 32'd0);
        fetch(2'b11, 32'h18, 32'h320, 32'h19, 32'h324); step();
        Csr_ExcpFlag = 1'b1; Id_IssueNum = 2'd1; step();
        chk("csr_flush_count", 32'(IQ_Count), 32'd0);
        fetch(2'b01, 32'h1A, 32'h328, 32'h0, 32'h0); step();
        Id_IssueNum = 2'd2; step();
        chk("short_deq_count", 32'(IQ_Count), 32'd0);

`ifdef IQ_BYPASS_EN
        fetch(2'b11, 32'h1B, 32'h32C, 32'h1C, 32'h330); Id_IssueNum = 2'd1;
        #1;
        chk("byp_inst0", IQ_Inst0, 32'h1B);
        chk("byp_valid", 32'(IQ_Valid), 32'b11);
        step();
        chk("byp_count", 32'(IQ_Count), 32'd1);
        chk("byp_rest_inst0", IQ_Inst0, 32'h1C);
`endif

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
